// File: rtl/dct_pingpong_transpose.sv
// rtl/dct_pingpong_transpose.sv - 8x8 ping-pong transpose buffer between DCT row and column passes
// Rows are written into one bank while the other, once full, is read out column by column.
module dct_pingpong_transpose #(
    parameter int DW = 12,
    parameter int N  = 8
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    input  logic signed [DW-1:0] DCT_data_o_z0,
    input  logic signed [DW-1:0] DCT_data_o_z1,
    input  logic signed [DW-1:0] DCT_data_o_z2,
    input  logic signed [DW-1:0] DCT_data_o_z3,
    input  logic signed [DW-1:0] DCT_data_o_z4,
    input  logic signed [DW-1:0] DCT_data_o_z5,
    input  logic signed [DW-1:0] DCT_data_o_z6,
    input  logic signed [DW-1:0] DCT_data_o_z7,
    input  logic                 data_en,
    output logic [N*DW-1:0]      data_out,
    output logic                 data_out_vld,
    output logic                 rd_end
);

    localparam int AW = $clog2(N);
    localparam logic [AW-1:0] LAST = AW'(N - 1);

    logic [DW-1:0]   r_mem [0:1][0:N-1][0:N-1];
    logic [DW-1:0]   w_row [0:N-1];
    logic [N*DW-1:0] w_col_word;

    logic [AW-1:0]   r_wr_row;
    logic            r_wr_bank;
    logic [1:0]      r_full;
    logic [1:0]      w_full_nxt;
    logic [AW-1:0]   r_rd_col;
    logic            r_rd_bank;
    logic            w_wr_last;
    logic            w_rd_go;
    logic            w_rd_last;

    logic [N*DW-1:0] r_data_out;
    logic            r_data_out_vld;
    logic            r_rd_end;

    assign w_row[0] = DCT_data_o_z0;
    assign w_row[1] = DCT_data_o_z1;
    assign w_row[2] = DCT_data_o_z2;
    assign w_row[3] = DCT_data_o_z3;
    assign w_row[4] = DCT_data_o_z4;
    assign w_row[5] = DCT_data_o_z5;
    assign w_row[6] = DCT_data_o_z6;
    assign w_row[7] = DCT_data_o_z7;

    assign w_wr_last = data_en && (r_wr_row == LAST);
    // A read runs whenever the bank under the read pointer is full; back-to-back blocks chain without a gap.
    assign w_rd_go   = r_full[r_rd_bank];
    assign w_rd_last = w_rd_go && (r_rd_col == LAST);

    always_comb begin
        w_full_nxt = r_full;
        if (w_rd_last) begin
            w_full_nxt[r_rd_bank] = 1'b0;
        end
        if (w_wr_last) begin
            w_full_nxt[r_wr_bank] = 1'b1;
        end
    end

    always_comb begin
        w_col_word = '0;
        for (int k = 0; k < N; k++) begin
            w_col_word[k*DW +: DW] = r_mem[r_rd_bank][k][r_rd_col];
        end
    end

    // Storage carries no reset: the full flags alone decide what is ever read.
    always_ff @(posedge sys_clk) begin
        if (data_en) begin
            for (int c = 0; c < N; c++) begin
                r_mem[r_wr_bank][r_wr_row][c] <= w_row[c];
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_wr_row       <= '0;
            r_wr_bank      <= 1'b0;
            r_full         <= 2'b00;
            r_rd_col       <= '0;
            r_rd_bank      <= 1'b0;
            r_data_out     <= '0;
            r_data_out_vld <= 1'b0;
            r_rd_end       <= 1'b0;
        end else begin
            if (data_en) begin
                r_wr_row <= r_wr_row + 1'b1;
                if (w_wr_last) begin
                    r_wr_bank <= ~r_wr_bank;
                end
            end
            r_full <= w_full_nxt;
            if (w_rd_go) begin
                r_data_out     <= w_col_word;
                r_data_out_vld <= 1'b1;
                r_rd_end       <= w_rd_last;
                r_rd_col       <= r_rd_col + 1'b1;
                if (w_rd_last) begin
                    r_rd_bank <= ~r_rd_bank;
                end
            end else begin
                r_data_out_vld <= 1'b0;
                r_rd_end       <= 1'b0;
            end
        end
    end

    assign data_out     = r_data_out;
    assign data_out_vld = r_data_out_vld;
    assign rd_end       = r_rd_end;

endmodule

// File: tb/tb_dct_pingpong_transpose.sv
// tb/tb_dct_pingpong_transpose.sv - scoreboard bench for dct_pingpong_transpose
module tb_dct_pingpong_transpose;

    localparam int DW = 12;
    localparam int N  = 8;

    logic            sys_clk;
    logic            sys_rst_n;
    logic [N*DW-1:0] row_in;
    logic            data_en;
    logic [N*DW-1:0] data_out;
    logic            data_out_vld;
    logic            rd_end;

    typedef struct {
        int              cyc;
        logic [N*DW-1:0] data;
        logic            last;
    } exp_t;

    exp_t            sb[$];
    logic [N*DW-1:0] m_rows [0:N-1];
    int              m_row;
    int              cyc;
    int              n_tests;
    int              n_fail;
    int              n_end;
    bit              chk_zero;

    dct_pingpong_transpose #(.DW(DW), .N(N)) u_dut (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .DCT_data_o_z0(row_in[0*DW +: DW]),
        .DCT_data_o_z1(row_in[1*DW +: DW]),
        .DCT_data_o_z2(row_in[2*DW +: DW]),
        .DCT_data_o_z3(row_in[3*DW +: DW]),
        .DCT_data_o_z4(row_in[4*DW +: DW]),
        .DCT_data_o_z5(row_in[5*DW +: DW]),
        .DCT_data_o_z6(row_in[6*DW +: DW]),
        .DCT_data_o_z7(row_in[7*DW +: DW]),
        .data_en      (data_en),
        .data_out     (data_out),
        .data_out_vld (data_out_vld),
        .rd_end       (rd_end)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc = cyc + 1;

    task automatic check(input string tag, input logic [N*DW-1:0] got, input logic [N*DW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(negedge sys_clk) begin
        if (sys_rst_n) begin
            if (rd_end) n_end++;
            if (data_out_vld) begin
                if (sb.size() == 0) begin
                    check("unexpected_vld", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("col_data", data_out, e.data);
                    check("col_rd_end", rd_end, e.last);
                    check("col_cycle", cyc, e.cyc);
                end
            end else begin
                check("rd_end_idle", rd_end, 0);
                if (sb.size() > 0 && sb[0].cyc <= cyc) begin
                    check("missing_col", cyc, sb[0].cyc);
                    void'(sb.pop_front());
                end
            end
            if (chk_zero) begin
                check("idle_data", data_out, 0);
                check("idle_vld", data_out_vld, 0);
            end
        end
    end

    task automatic drive(input logic en, input logic [N*DW-1:0] row);
        data_en = en;
        row_in  = row;
        @(posedge sys_clk);
        #1;
        if (en) begin
            m_rows[m_row] = row;
            if (m_row == N - 1) begin
                for (int c = 0; c < N; c++) begin
                    exp_t e;
                    e.data = '0;
                    for (int k = 0; k < N; k++) e.data[k*DW +: DW] = m_rows[k][c*DW +: DW];
                    e.cyc  = cyc + 1 + c;
                    e.last = (c == N - 1);
                    sb.push_back(e);
                end
            end
            m_row = (m_row + 1) % N;
        end
        data_en = 1'b0;
    endtask

    function automatic logic [N*DW-1:0] mk_row(input int base);
        logic [N*DW-1:0] r;
        r = '0;
        for (int c = 0; c < N; c++) r[c*DW +: DW] = DW'(base + c);
        return r;
    endfunction

    task automatic drain();
        for (int i = 0; i < 20 && sb.size() > 0; i++) drive(1'b0, '0);
        drive(1'b0, '0);
        if (sb.size() != 0) check("drain_timeout", sb.size(), 0);
    endtask

    task automatic async_reset();
        #2 sys_rst_n = 1'b0;
        #1;
        check("rst_data", data_out, 0);
        check("rst_vld", data_out_vld, 0);
        check("rst_rd_end", rd_end, 0);
        sb.delete();
        m_row = 0;
        @(posedge sys_clk);
        #1 sys_rst_n = 1'b1;
    endtask

    initial begin
        int ends0;
        logic [N*DW-1:0] r;
        n_tests = 0; n_fail = 0; n_end = 0; cyc = 0; m_row = 0; chk_zero = 0;
        sys_rst_n = 1'b0; data_en = 1'b0; row_in = '0;
        repeat (2) @(posedge sys_clk);
        #1;
        check("reset_data", data_out, 0);
        check("reset_vld", data_out_vld, 0);
        check("reset_rd_end", rd_end, 0);
        sys_rst_n = 1'b1;

        chk_zero = 1;
        for (int i = 0; i < 20; i++) drive(1'b0, mk_row(100));
        chk_zero = 0;

        for (int b = 0; b < 2; b++)
            for (int i = 0; i < N; i++) drive(1'b1, mk_row(8 * b));
        drain();

        for (int i = 0; i < N; i++) drive(1'b1, mk_row(8 * i));
        drain();

        ends0 = n_end;
        for (int i = 0; i < 3 * N; i++) begin
            for (int c = 0; c < N; c++) r[c*DW +: DW] = DW'($urandom_range(0, 4095));
            drive(1'b1, r);
        end
        drain();
        check("three_block_ends", n_end - ends0, 3);

        for (int i = 0; i < 2 * N; i++) drive((i % 2) == 0, mk_row(8 * (i / 2)));
        drain();

        for (int i = 0; i < 4; i++) drive(1'b1, mk_row(500 + i));
        async_reset();
        for (int i = 0; i < N; i++) drive(1'b1, mk_row(200 + 8 * i));
        repeat (3) drive(1'b0, '0);
        check("mid_read_vld", data_out_vld, 1);
        async_reset();
        for (int i = 0; i < 5; i++) drive(1'b0, '0);
        for (int i = 0; i < N; i++) drive(1'b1, mk_row(-40 + 8 * i));
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
